pc_sequencer: RTL and testbench

Next-PC controller for the 5-stage MIPS pipeline. It sits in front of the PC register, driving that register's input every cycle. It arbitrates between sequential fetch, EX-stage branches, ID-stage jumps, exceptions, interrupts and `eret`. It also sequences interrupt entry (pipeline drain, EPC capture, vectoring) and generates stage flush signals.

---
 rtl/pc_sequencer_if.sv | 44 ++++
 rtl/pc_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the pipeline and the next-PC sequencer.
// The pipeline drives the master side and the sequencer drives the slave side.
interface pc_sequencer_if;
  logic [31:0] pc_cur_i;
  logic        stall_i;
  logic        br_req_i;
  logic [31:0] br_target_i;
  logic        jmp_req_i;
  logic [31:0] jmp_target_i;
  logic        exc_req_i;
  logic [31:0] exc_pc_i;
  logic        eret_i;
  logic        irq_i;
  logic [31:0] pc_next_o;
  logic        flush_if_o;
  logic        flush_id_o;
  logic        flush_ex_o;
  logic [31:0] epc_o;
  logic        in_kernel_o;

  modport master (
    output pc_cur_i, stall_i,
    output br_req_i, br_target_i,
    output jmp_req_i, jmp_target_i,
    output exc_req_i, exc_pc_i,
    output eret_i, irq_i,
    input  pc_next_o,
    input  flush_if_o, flush_id_o,
    input  flush_ex_o,
    input  epc_o, in_kernel_o
  );

  modport slave (
    input  pc_cur_i, stall_i,
    input  br_req_i, br_target_i,
    input  jmp_req_i, jmp_target_i,
    input  exc_req_i, exc_pc_i,
    input  eret_i, irq_i,
    output pc_next_o,
    output flush_if_o, flush_id_o,
    output flush_ex_o,
    output epc_o, in_kernel_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC arbiter: branches, jumps, exceptions, eret and interrupt entry.
// Define PC_SEQ_IRQ_EN to compile in irq handling and the DRAIN state.
module pc_sequencer (
  input logic clk,
  input logic reset,
  pc_sequencer_if.slave bus
);

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
  localparam logic [31:0] ALIGN      = 32'hFFFF_FFFC;

`ifdef PC_SEQ_IRQ_EN
  localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
  localparam logic [1:0]  DRAIN_CYCLES = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    KERNEL = 2'd1,
    DRAIN  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    KERNEL = 2'd1
  } state_t;
`endif

  state_t      state;
  state_t      state_n;
  logic [31:0] epc;
  logic [31:0] epc_n;
  logic        in_kernel;
  logic [31:0] nxt;
  logic [31:0] pc_inc;
  logic        f_if;
  logic        f_id;
  logic        f_ex;

  logic s_exc;
  logic s_br;
  logic s_jmp;
  logic s_eret;
  logic s_hold;

  assign pc_inc = bus.pc_cur_i + 32'd4;

  // one-hot request selects, highest priority first
  assign s_exc  = bus.exc_req_i;
  assign s_br   = bus.br_req_i & ~s_exc;
  assign s_jmp  = bus.jmp_req_i & ~bus.stall_i
                & ~s_exc & ~s_br;
  assign s_eret = bus.eret_i & ~bus.jmp_req_i
                & ~bus.stall_i & ~s_exc & ~s_br;
  assign s_hold = bus.stall_i & ~s_exc & ~s_br;

`ifdef PC_SEQ_IRQ_EN
  logic [31:0] resume;
  logic [31:0] resume_n;
  logic [1:0]  drain_cnt;
  logic [1:0]  cnt_n;
  logic        s_irq;
  logic        d_exit;

  assign s_irq  = bus.irq_i & (state == RUN)
                & ~bus.stall_i & ~s_exc & ~s_br
                & ~bus.jmp_req_i & ~bus.eret_i;
  assign d_exit = (drain_cnt == 2'd0) & ~s_exc;
`else
  logic irq_unused;
  assign irq_unused = bus.irq_i;
`endif

  always_comb begin
    nxt     = pc_inc;
    f_if    = 1'b0;
    f_id    = 1'b0;
    f_ex    = 1'b0;
    state_n = state;
    epc_n   = epc;
`ifdef PC_SEQ_IRQ_EN
    resume_n = resume;
    cnt_n    = drain_cnt;
`endif
    unique case (state)
`ifdef PC_SEQ_IRQ_EN
      DRAIN: begin
        f_if = 1'b1;
        nxt  = resume;
        unique case (1'b1)
          s_exc: begin
            nxt     = EXC_VECTOR;
            f_id    = 1'b1;
            f_ex    = 1'b1;
            epc_n   = bus.exc_pc_i;
            state_n = KERNEL;
          end
          d_exit: begin
            nxt     = IRQ_VECTOR;
            epc_n   = resume;
            state_n = KERNEL;
          end
          default: begin
            if (!bus.stall_i)
              cnt_n = drain_cnt - 2'd1;
            if (s_br) begin
              resume_n = bus.br_target_i & ALIGN;
              f_id     = 1'b1;
            end else if (s_jmp) begin
              resume_n = bus.jmp_target_i & ALIGN;
            end
          end
        endcase
      end
`endif
      default: begin
        unique case (1'b1)
          s_exc: begin
            nxt     = EXC_VECTOR;
            f_if    = 1'b1;
            f_id    = 1'b1;
            f_ex    = 1'b1;
            state_n = KERNEL;
            if (state == RUN)
              epc_n = bus.exc_pc_i;
          end
          s_br: begin
            nxt  = bus.br_target_i & ALIGN;
            f_if = 1'b1;
            f_id = 1'b1;
          end
          s_jmp: begin
            nxt  = bus.jmp_target_i & ALIGN;
            f_if = 1'b1;
          end
          s_eret: begin
            nxt     = epc & ALIGN;
            f_if    = 1'b1;
            state_n = RUN;
          end
`ifdef PC_SEQ_IRQ_EN
          s_irq: begin
            nxt      = bus.pc_cur_i;
            f_if     = 1'b1;
            resume_n = bus.pc_cur_i;
            cnt_n    = DRAIN_CYCLES;
            state_n  = DRAIN;
          end
`endif
          s_hold: nxt = bus.pc_cur_i;
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      epc       <= '0;
      in_kernel <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
      resume    <= '0;
      drain_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      epc       <= epc_n;
      in_kernel <= (state_n == KERNEL);
`ifdef PC_SEQ_IRQ_EN
      resume    <= resume_n;
      drain_cnt <= cnt_n;
`endif
    end
  end

  assign bus.pc_next_o   = reset ? RESET_PC : nxt;
  assign bus.flush_if_o  = reset | f_if;
  assign bus.flush_id_o  = reset | f_id;
  assign bus.flush_ex_o  = reset | f_ex;
  assign bus.epc_o       = epc;
  assign bus.in_kernel_o = in_kernel;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based scoreboard.
// Irq/DRAIN steps run only when PC_SEQ_IRQ_EN is defined.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [2:0]  fl;
    logic [31:0] epc;
    logic        ink;
  } exp_t;

  exp_t q[$];

  task automatic idle(input logic [31:0] pc);
    bus.pc_cur_i     = pc;
    bus.stall_i      = 1'b0;
    bus.br_req_i     = 1'b0;
    bus.br_target_i  = '0;
    bus.jmp_req_i    = 1'b0;
    bus.jmp_target_i = '0;
    bus.exc_req_i    = 1'b0;
    bus.exc_pc_i     = '0;
    bus.eret_i       = 1'b0;
    bus.irq_i        = 1'b0;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] pc,
    input logic [2:0]  fl,
    input logic [31:0] epc,
    input logic        ink
  );
    exp_t e;
    logic [2:0] f;
    e.tag = tag;
    e.pc  = pc;
    e.fl  = fl;
    e.epc = epc;
    e.ink = ink;
    q.push_back(e);
    @(negedge clk);
    total++;
    assert (q.size() > 0) else begin
      bad++;
      $error("FAIL %s scoreboard got=empty want=entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      f = {bus.flush_if_o, bus.flush_id_o, bus.flush_ex_o};
      total++;
      assert (bus.pc_next_o === e.pc) else begin
        bad++;
        $error("FAIL %s pc_next got=%h want=%h",
               e.tag, bus.pc_next_o, e.pc);
      end
      total++;
      assert (f === e.fl) else begin
        bad++;
        $error("FAIL %s flush got=%b want=%b",
               e.tag, f, e.fl);
      end
      total++;
      assert (bus.epc_o === e.epc) else begin
        bad++;
        $error("FAIL %s epc got=%h want=%h",
               e.tag, bus.epc_o, e.epc);
      end
      total++;
      assert (bus.in_kernel_o === e.ink) else begin
        bad++;
        $error("FAIL %s in_kernel got=%b want=%b",
               e.tag, bus.in_kernel_o, e.ink);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle(32'h0);
    chk("reset", 32'h0, 3'b111, 32'h0, 1'b0);
    reset = 1'b0;

    idle(32'h0);
    chk("seq0", 32'h4, 3'b000, 32'h0, 1'b0);
    idle(32'h4);
    chk("seq1", 32'h8, 3'b000, 32'h0, 1'b0);
    idle(32'h8);
    chk("seq2", 32'hC, 3'b000, 32'h0, 1'b0);

    idle(32'h20);
    bus.br_req_i     = 1'b1;
    bus.br_target_i  = 32'h100;
    bus.jmp_req_i    = 1'b1;
    bus.jmp_target_i = 32'h200;
    bus.stall_i      = 1'b1;
    chk("br_win", 32'h100, 3'b110, 32'h0, 1'b0);

    idle(32'h100);
    bus.br_req_i    = 1'b1;
    bus.br_target_i = 32'h103;
    chk("br_align", 32'h100, 3'b110, 32'h0, 1'b0);

    idle(32'h100);
    bus.jmp_req_i    = 1'b1;
    bus.jmp_target_i = 32'h202;
    chk("jmp", 32'h200, 3'b100, 32'h0, 1'b0);

    idle(32'h24);
    bus.jmp_req_i    = 1'b1;
    bus.jmp_target_i = 32'h300;
    bus.stall_i      = 1'b1;
    chk("jmp_stall", 32'h24, 3'b000, 32'h0, 1'b0);

    idle(32'h30);
    bus.exc_req_i = 1'b1;
    bus.exc_pc_i  = 32'h2C;
    chk("exc_run", 32'h8000_0008, 3'b111, 32'h0, 1'b0);

    idle(32'h8000_0008);
    bus.irq_i = 1'b1;
    chk("kern_irq", 32'h8000_000C, 3'b000, 32'h2C, 1'b1);

    idle(32'h8000_000C);
    bus.exc_req_i = 1'b1;
    bus.exc_pc_i  = 32'h50;
    chk("exc_kern", 32'h8000_0008, 3'b111, 32'h2C, 1'b1);

    idle(32'h8000_0008);
    bus.eret_i  = 1'b1;
    bus.stall_i = 1'b1;
    chk("eret_stall", 32'h8000_0008, 3'b000, 32'h2C, 1'b1);

    idle(32'h8000_0008);
    bus.eret_i = 1'b1;
    chk("eret", 32'h2C, 3'b100, 32'h2C, 1'b1);

    idle(32'h2C);
    chk("back_run", 32'h30, 3'b000, 32'h2C, 1'b0);

    idle(32'h30);
    bus.eret_i = 1'b1;
    chk("eret_run", 32'h2C, 3'b100, 32'h2C, 1'b0);

    idle(32'hFFFF_FFFC);
    chk("wrap", 32'h0, 3'b000, 32'h2C, 1'b0);

`ifdef PC_SEQ_IRQ_EN
    idle(32'h40);
    bus.irq_i = 1'b1;
    chk("irq_take", 32'h40, 3'b100, 32'h2C, 1'b0);

    idle(32'h40);
    bus.jmp_req_i    = 1'b1;
    bus.jmp_target_i = 32'h80;
    chk("drain2", 32'h40, 3'b100, 32'h2C, 1'b0);

    idle(32'h40);
    chk("drain1", 32'h80, 3'b100, 32'h2C, 1'b0);

    idle(32'h40);
    chk("drain0", 32'h8000_0004, 3'b100, 32'h2C, 1'b0);

    idle(32'h8000_0004);
    bus.irq_i  = 1'b1;
    bus.eret_i = 1'b1;
    chk("irq_eret", 32'h80, 3'b100, 32'h80, 1'b1);

    idle(32'h80);
    bus.irq_i = 1'b1;
    chk("irq_again", 32'h80, 3'b100, 32'h80, 1'b0);

    idle(32'h80);
    bus.exc_req_i = 1'b1;
    bus.exc_pc_i  = 32'h1C;
    chk("exc_drain", 32'h8000_0008, 3'b111, 32'h80, 1'b0);

    idle(32'h8000_0008);
    chk("exc_epc", 32'h8000_000C, 3'b000, 32'h1C, 1'b1);

    idle(32'h8000_000C);
    bus.eret_i = 1'b1;
    chk("eret2", 32'h1C, 3'b100, 32'h1C, 1'b1);

    idle(32'h1C);
    bus.irq_i = 1'b1;
    chk("irq3", 32'h1C, 3'b100, 32'h1C, 1'b0);

    reset = 1'b1;
    idle(32'h1C);
    chk("rst_drain", 32'h0, 3'b111, 32'h0, 1'b0);
    reset = 1'b0;

    idle(32'h0);
    chk("post_rst", 32'h4, 3'b000, 32'h0, 1'b0);
`else
    idle(32'h60);
    bus.irq_i = 1'b1;
    chk("irq_off0", 32'h64, 3'b000, 32'h2C, 1'b0);

    idle(32'h64);
    bus.irq_i = 1'b1;
    chk("irq_off1", 32'h68, 3'b000, 32'h2C, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
